prm_edge_scan_ctrl: RTL and testbench
=====================================

# prm_edge_scan_ctrl

Sequencer for the PRM obstacle-check logic bank. It takes a stream of 15-bit obstacle codes (the A..O inputs of the edge-check modules) and, for each code, sweeps every group of edge checkers. It accumulates the per-edge `edge_mask` results into an external edge-mask RAM, ORing them across all obstacles in a job. It sits between the host/obstacle loader and the combinational checker bank, and leaves one blocked-bit per roadmap edge in the RAM.

## Interface
Parameters:
- N_EDGE, 1024, total edges covered by the checker bank.
- GRP_W, 32, checkers evaluated in parallel per group (one `edge_mask` bit each).
- CODE_W, 15, obstacle code width (bit 0 = A … bit 14 = O).
- Derived: N_GRP = N_EDGE/GRP_W (must be ≥2, integer); AW = clog2(N_GRP).

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- start  in  1  job start pulse; honoured only in IDLE.
- abort  in  1  cancel running job; ignored in IDLE.
- obs_num  in  8  obstacle count for the job, sampled on accepted start.
- obs_valid  in  1  obstacle code valid.
- obs_ready  out  1  controller ready for a code.
- obs_code  in  CODE_W  obstacle code.
- chk_code  out  CODE_W  code driven to the checker bank.
- chk_grp  out  AW  checker group select.
- chk_mask  in  GRP_W  bank result for (chk_code, chk_grp), combinational and same-cycle.
- mem_raddr  out  AW  RAM read address; RAM has 1-cycle read latency.
- mem_rdata  in  GRP_W  RAM read data.
- mem_we  out  1  RAM write enable.
- mem_waddr  out  AW  RAM write address.
- mem_wdata  out  GRP_W  RAM write data.
- busy  out  1  job in progress.
- done  out  1  one-cycle job-complete pulse.
- any_blocked  out  1  any written word was non-zero during the last completed job; updated with done and held until the next accepted start.

## Operation
- States: IDLE, CLEAR, FETCH, SWEEP, DONE.
- IDLE:
  - start=1 and abort=0: latch obs_num into rem, clear any_blocked and first flag state.
  - Go to CLEAR if obs_num==0, else FETCH.
- CLEAR: mem_we=1, mem_waddr=cnt, mem_wdata=0, cnt 0..N_GRP-1; after the last write go to DONE.
- FETCH:
  - obs_ready=1.
  - On obs_valid&obs_ready: latch obs_code into chk_code, set g=0, go to SWEEP.
  - first=1 iff this is the job's first obstacle.
- SWEEP (issue stage), per cycle: chk_grp=g, mem_raddr=g, g++.
  - After g=N_GRP-1, decrement rem; go to FETCH if rem≠0, else DONE.
- Write stage (free-running, one cycle behind issue):
  - Registers mask_q=chk_mask, grp_q=g, vld_q.
  - Next cycle: mem_we=vld_q, mem_waddr=grp_q, mem_wdata = first ? mask_q : mask_q|mem_rdata.
  - If the write is non-zero, any_blocked_acc is set.
- No RAW hazard: address g is read once per sweep, and its write lands one cycle later, before the next sweep reads it (N_GRP≥2).
- DONE (1 cycle): done=1; the last group's write occurs this cycle; any_blocked updated; go to IDLE.
- abort in a non-IDLE state:
  - Next state is IDLE; busy=0 and vld_q=0 next cycle, so the pending write is dropped.
  - No done pulse; RAM contents are undefined.
- start while busy is ignored. obs_num is not re-sampled mid-job.

## Timing
- Reset values: all outputs 0 (obs_ready, busy, done, mem_we, any_blocked, chk_code, chk_grp, mem_raddr, mem_waddr, mem_wdata).
- Reset mid-job acts like abort, but also clears any_blocked.
- Start accepted in cycle 0; busy=1 from cycle 1 through the DONE cycle inclusive.
- Cycle budgets:
  - Each obstacle costs 1 FETCH cycle plus N_GRP SWEEP cycles, with obs_valid held high.
  - Job with k≥1 obstacles: done in cycle 1+k·(N_GRP+1); each idle FETCH cycle adds 1.
  - obs_num=0: CLEAR occupies cycles 1..N_GRP; done in cycle N_GRP+1.
- obs_ready is high only in FETCH; obs_code is consumed exactly once per handshake.
- chk_code is stable for the whole sweep.

## Test plan
Bench uses N_EDGE=64, GRP_W=32 (N_GRP=2) with behavioural bank and RAM models.
1. Assert RST mid-sweep for 1 cycle → all outputs 0 immediately (async); no further mem_we; the next start runs normally.
2. obs_num=1, code 15'h1234, bank returns 32'hA5A50000|grp → RAM[0]=A5A50000, RAM[1]=A5A50001 (no OR on first); done in cycle 4; any_blocked=1.
3. obs_num=2, RAM preloaded FFFFFFFF, masks 32'h000000F0 then 32'h0000000F → RAM[0]=RAM[1]=000000FF; done in cycle 7.
4. obs_num=0, RAM preloaded FFFFFFFF → both words 0 in cycles 1–2; done in cycle 3; any_blocked=0.
5. obs_valid low for 5 cycles in the first FETCH (obs_num=1) → obs_ready stays 1, no mem_we during the stall; done in cycle 9.
6. abort in the second SWEEP cycle → busy=0 next cycle, no done, no mem_we afterwards; start pulsed while busy (before the abort) has no effect.

Source files
------------

// File: rtl/prm_edge_scan_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prm_edge_scan_if                                                     |
// | Job control, obstacle stream, checker bank and edge-mask RAM bundle. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface prm_edge_scan_if #(
  parameter int N_EDGE = 1024,
  parameter int GRP_W  = 32,
  parameter int CODE_W = 15
);
  localparam int N_GRP = N_EDGE / GRP_W;
  localparam int AW    = $clog2(N_GRP);

  logic              start;
  logic              abort;
  logic [7:0]        obs_num;
  logic              obs_valid;
  logic              obs_ready;
  logic [CODE_W-1:0] obs_code;
  logic [CODE_W-1:0] chk_code;
  logic [AW-1:0]     chk_grp;
  logic [GRP_W-1:0]  chk_mask;
  logic [AW-1:0]     mem_raddr;
  logic [GRP_W-1:0]  mem_rdata;
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [GRP_W-1:0]  mem_wdata;
  logic              busy;
  logic              done;
  logic              any_blocked;

  modport master (
    input  start, abort, obs_num, obs_valid, obs_code, chk_mask, mem_rdata,
    output obs_ready, chk_code, chk_grp, mem_raddr, mem_we, mem_waddr,
           mem_wdata, busy, done, any_blocked
  );

  modport slave (
    output start, abort, obs_num, obs_valid, obs_code, chk_mask, mem_rdata,
    input  obs_ready, chk_code, chk_grp, mem_raddr, mem_we, mem_waddr,
           mem_wdata, busy, done, any_blocked
  );
endinterface
`default_nettype wire

// File: rtl/prm_edge_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prm_edge_scan_ctrl                                                   |
// | Sweeps every checker group per obstacle and ORs edge masks into RAM. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module prm_edge_scan_ctrl #(
  parameter int N_EDGE = 1024,
  parameter int GRP_W  = 32,
  parameter int CODE_W = 15
) (
  input  wire logic         CLK,
  input  wire logic         RST,
  prm_edge_scan_if.master   bus
);
  localparam int N_GRP = N_EDGE / GRP_W;
  localparam int AW    = $clog2(N_GRP);
  localparam logic [AW-1:0] G_LAST = AW'(N_GRP - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FETCH = 3'd2,
    S_SWEEP = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        rem_q, rem_d;
  logic [AW-1:0]     g_q, g_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              first_pend_q, first_pend_d;
  logic              first_q, first_d;
  logic [GRP_W-1:0]  mask_q, mask_d;
  logic [AW-1:0]     grp_q, grp_d;
  logic              vld_q, vld_d;
  logic              acc_q, acc_d;
  logic              any_blocked_q, any_blocked_d;

  logic [GRP_W-1:0]  wr_data;
  logic              wr_nz;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= S_IDLE;
      rem_q         <= '0;
      g_q           <= '0;
      code_q        <= '0;
      first_pend_q  <= 1'b0;
      first_q       <= 1'b0;
      mask_q        <= '0;
      grp_q         <= '0;
      vld_q         <= 1'b0;
      acc_q         <= 1'b0;
      any_blocked_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rem_q         <= rem_d;
      g_q           <= g_d;
      code_q        <= code_d;
      first_pend_q  <= first_pend_d;
      first_q       <= first_d;
      mask_q        <= mask_d;
      grp_q         <= grp_d;
      vld_q         <= vld_d;
      acc_q         <= acc_d;
      any_blocked_q <= any_blocked_d;
    end
  end

  // Write stage: the first obstacle of a job overwrites, later ones merge.
  always_comb begin
    wr_data = first_q ? mask_q : (mask_q | bus.mem_rdata);
    wr_nz   = vld_q && (wr_data != '0);
  end

  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    g_d           = g_q;
    code_d        = code_q;
    first_pend_d  = first_pend_q;
    first_d       = first_q;
    mask_d        = bus.chk_mask;
    grp_d         = g_q;
    vld_d         = 1'b0;
    acc_d         = acc_q | wr_nz;
    any_blocked_d = any_blocked_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          rem_d         = bus.obs_num;
          acc_d         = 1'b0;
          any_blocked_d = 1'b0;
          first_pend_d  = 1'b1;
          g_d           = '0;
          state_d       = (bus.obs_num == 8'd0) ? S_CLEAR : S_FETCH;
        end
      end
      S_CLEAR: begin
        g_d = g_q + AW'(1);
        if (g_q == G_LAST) begin
          g_d     = '0;
          state_d = S_DONE;
        end
      end
      S_FETCH: begin
        if (bus.obs_valid) begin
          code_d       = bus.obs_code;
          g_d          = '0;
          first_d      = first_pend_q;
          first_pend_d = 1'b0;
          state_d      = S_SWEEP;
        end
      end
      S_SWEEP: begin
        vld_d = 1'b1;
        g_d   = g_q + AW'(1);
        if (g_q == G_LAST) begin
          g_d     = '0;
          rem_d   = rem_q - 8'd1;
          state_d = (rem_q == 8'd1) ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        any_blocked_d = acc_q | wr_nz;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort drops the in-flight write along with the job.
    if (bus.abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      vld_d   = 1'b0;
    end
  end

  always_comb begin
    bus.obs_ready   = (state_q == S_FETCH);
    bus.chk_code    = code_q;
    bus.chk_grp     = g_q;
    bus.mem_raddr   = g_q;
    bus.mem_we      = vld_q || (state_q == S_CLEAR);
    bus.mem_waddr   = (state_q == S_CLEAR) ? g_q : grp_q;
    bus.mem_wdata   = vld_q ? wr_data : '0;
    bus.busy        = (state_q != S_IDLE);
    bus.done        = (state_q == S_DONE);
    // The final write lands in the DONE cycle, so fold it in combinationally.
    bus.any_blocked = (state_q == S_DONE) ? (acc_q | wr_nz) : any_blocked_q;
  end
endmodule
`default_nettype wire

// File: tb/tb_prm_edge_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_prm_edge_scan_ctrl                                                |
// | Directed and randomized jobs against a job-level edge-mask model.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_prm_edge_scan_ctrl;
  localparam int N_EDGE = 64;
  localparam int GRP_W  = 32;
  localparam int CODE_W = 15;
  localparam int N_GRP  = N_EDGE / GRP_W;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  prm_edge_scan_if #(.N_EDGE(N_EDGE), .GRP_W(GRP_W), .CODE_W(CODE_W)) bus ();

  prm_edge_scan_ctrl #(.N_EDGE(N_EDGE), .GRP_W(GRP_W), .CODE_W(CODE_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          bank_mode = 0;
  logic [31:0] key_a = '0;
  logic [31:0] key_b = '0;
  logic [14:0] job_codes [0:15];
  logic [31:0] ram [0:N_GRP-1];
  logic        preload_en = 1'b0;
  logic [31:0] preload_val = '0;

  function automatic logic [31:0] bank_fn(input int mode, input logic [31:0] ka,
                                          input logic [31:0] kb, input logic [14:0] code,
                                          input int grp);
    case (mode)
      0:       return 32'hA5A50000 | 32'(grp);
      1:       return {17'd0, code};
      default: return ((32'(code) * 32'h9E3779B1) ^ (32'(grp) * 32'h85EBCA6B) ^ ka) & kb;
    endcase
  endfunction

  always_comb bus.chk_mask = bank_fn(bank_mode, key_a, key_b, bus.chk_code, int'(bus.chk_grp));

  always_ff @(posedge CLK) begin
    if (preload_en) begin
      for (int i = 0; i < N_GRP; i++) ram[i] <= preload_val;
    end else if (bus.mem_we) begin
      ram[bus.mem_waddr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= ram[bus.mem_raddr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [31:0] v);
    preload_val = v;
    preload_en  = 1'b1;
    @(negedge CLK);
    preload_en  = 1'b0;
  endtask

  // One job: expected RAM = OR of bank results over all codes (zero when k=0).
  task automatic run_job(input string tag, input int k, input int first_stall, input bit rnd);
    logic [31:0] exp_w [0:N_GRP-1];
    bit exp_ab = 1'b0;
    int idx = 0, stall = first_stall, stalls = 0, nwr = 0, done_c = -1, exp_c;
    bit busy_bad = 0, code_bad = 0, ready_bad = 0, stall_we_bad = 0;
    for (int g = 0; g < N_GRP; g++) begin
      exp_w[g] = '0;
      for (int i = 0; i < k; i++) exp_w[g] |= bank_fn(bank_mode, key_a, key_b, job_codes[i], g);
      if (exp_w[g] != '0) exp_ab = 1'b1;
    end
    bus.start   = 1'b1;
    bus.obs_num = 8'(k);
    @(negedge CLK);
    bus.start = 1'b0;
    for (int c = 1; c <= 2000; c++) begin
      if (bus.mem_we) nwr++;
      if (!bus.busy) busy_bad = 1'b1;
      if (bus.done) begin
        done_c = c;
        break;
      end
      if (bus.obs_ready) begin
        if (idx == 0 && bus.mem_we) stall_we_bad = 1'b1;
        if (stall > 0) begin
          bus.obs_valid = 1'b0;
          stall--;
          stalls++;
        end else if (idx < k) begin
          bus.obs_valid = 1'b1;
          bus.obs_code  = job_codes[idx];
          idx++;
          stall = (rnd && $urandom_range(3) == 0) ? int'($urandom_range(3)) : 0;
        end else begin
          ready_bad     = 1'b1;
          bus.obs_valid = 1'b0;
        end
      end else begin
        if (idx > 0 && bus.chk_code !== job_codes[idx-1]) code_bad = 1'b1;
        bus.obs_valid = rnd ? 1'($urandom_range(1)) : 1'b0;
        bus.obs_code  = 15'($urandom);
      end
      bus.start   = rnd ? ($urandom_range(3) == 0) : 1'b0;
      bus.obs_num = 8'($urandom);
      @(negedge CLK);
    end
    bus.start     = 1'b0;
    bus.obs_valid = 1'b0;
    exp_c = 1 + ((k == 0) ? N_GRP : k * (N_GRP + 1)) + stalls;
    chk({tag, " done_cycle"}, 64'(done_c), 64'(exp_c));
    chk({tag, " any_blocked_at_done"}, 64'(bus.any_blocked), 64'(exp_ab));
    chk({tag, " write_count"}, 64'(nwr), 64'((k == 0) ? N_GRP : k * N_GRP));
    chk({tag, " busy/code/ready/stall_we"}, {busy_bad, code_bad, ready_bad, stall_we_bad}, 64'd0);
    @(negedge CLK);
    chk({tag, " idle_after_done"}, {bus.busy, bus.done, bus.any_blocked}, {2'b00, exp_ab});
    for (int g = 0; g < N_GRP; g++) chk({tag, " ram_word"}, 64'(ram[g]), 64'(exp_w[g]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit bad;
    bus.start = 1'b0; bus.abort = 1'b0; bus.obs_num = '0;
    bus.obs_valid = 1'b0; bus.obs_code = '0;
    @(negedge CLK);
    chk("reset_outputs", {bus.obs_ready, bus.busy, bus.done, bus.mem_we, bus.any_blocked,
        bus.chk_code, bus.chk_grp, bus.mem_raddr, bus.mem_waddr, bus.mem_wdata}, 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // Single obstacle: first obstacle overwrites the preloaded words.
    preload(32'hFFFFFFFF);
    bank_mode = 0; job_codes[0] = 15'h1234;
    run_job("t2_single", 1, 0, 1'b0);

    // Reset mid-sweep: outputs drop asynchronously and any_blocked clears.
    bus.start = 1'b1; bus.obs_num = 8'd1;
    @(negedge CLK);
    bus.start = 1'b0; bus.obs_valid = 1'b1; bus.obs_code = 15'h0777;
    @(negedge CLK);
    bus.obs_valid = 1'b0;
    chk("t1 in_sweep", {bus.busy, bus.obs_ready}, 64'b10);
    RST = 1'b1;
    #1;
    chk("t1 async_reset_outputs", {bus.obs_ready, bus.busy, bus.done, bus.mem_we, bus.any_blocked,
        bus.chk_code, bus.chk_grp, bus.mem_raddr, bus.mem_waddr, bus.mem_wdata}, 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    bad = 1'b0;
    repeat (4) begin
      if (bus.mem_we || bus.busy || bus.done || bus.any_blocked) bad = 1'b1;
      @(negedge CLK);
    end
    chk("t1 quiet_after_reset", 64'(bad), 64'd0);

    // Two obstacles merged by OR.
    preload(32'hFFFFFFFF);
    bank_mode = 1; job_codes[0] = 15'h00F0; job_codes[1] = 15'h000F;
    run_job("t3_two_obs", 2, 0, 1'b0);

    // Zero obstacles: clear pass only.
    preload(32'hFFFFFFFF);
    run_job("t4_clear", 0, 0, 1'b0);

    // Stall in the first fetch.
    preload(32'h12345678);
    bank_mode = 0; job_codes[0] = 15'h0abc;
    run_job("t5_stall", 1, 5, 1'b0);

    // Abort in the second sweep cycle, with a start pulse ignored before it.
    preload(32'hFFFFFFFF);
    bank_mode = 0;
    bus.start = 1'b1; bus.obs_num = 8'd2;
    @(negedge CLK);
    bus.start = 1'b0; bus.obs_valid = 1'b1; bus.obs_code = 15'h0042;
    @(negedge CLK);
    bus.obs_valid = 1'b0; bus.start = 1'b1; bus.obs_num = 8'd9;
    @(negedge CLK);
    chk("t6 before_abort", {bus.busy, bus.obs_ready, bus.chk_grp}, 64'b101);
    bus.start = 1'b0; bus.abort = 1'b1;
    @(negedge CLK);
    bus.abort = 1'b0;
    chk("t6 after_abort", {bus.busy, bus.obs_ready, bus.mem_we, bus.done}, 64'd0);
    bad = 1'b0;
    repeat (6) begin
      @(negedge CLK);
      if (bus.done || bus.mem_we || bus.busy) bad = 1'b1;
    end
    chk("t6 quiet_after_abort", 64'(bad), 64'd0);

    // Randomized jobs with stalls and stray start pulses.
    for (int j = 0; j < 20; j++) begin
      int k;
      k = int'($urandom_range(5));
      bank_mode = 2;
      key_a = $urandom;
      key_b = ($urandom_range(3) == 0) ? 32'd0 : $urandom;
      for (int i = 0; i < k; i++) job_codes[i] = 15'($urandom);
      preload($urandom);
      run_job("rnd_job", k, int'($urandom_range(2)), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
